// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: resolves load-use, memory-wait and redirect hazards into
// stall / flush_if_id / bubble_ex, and counts stalled cycles.
module pipe_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic                  id_rs1_used,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs2_used,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  perf_clr,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  bubble_ex,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam state_e           FLUSH_NEXT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu_haz, mem_haz, redir, mem_done;
  logic stall_c, flush_c, bubble_c;

  assign lu_haz = ex_valid & ex_is_load & (ex_rd != '0) &
                  ((id_rs1_used & (id_rs1 == ex_rd)) |
                   (id_rs2_used & (id_rs2 == ex_rd)));
  assign mem_haz  = mem_req & ~mem_ready;
  assign mem_done = mem_ready | ~mem_req;
  assign redir    = ex_redirect & ex_valid;

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    pend_d   = pend_q;
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_haz) begin
          stall_c = 1'b1;
          state_d = MEM_WAIT;
          if (redir) pend_d = 1'b1;
        end else if (redir) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          fcnt_d   = FLUSH_LOAD;
          state_d  = FLUSH_NEXT;
        end else if (lu_haz) begin
          bubble_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Execute is frozen here, so a redirect seen now is stale and ignored.
        if (!mem_done) begin
          stall_c = 1'b1;
        end else if (pend_q) begin
          pend_d   = 1'b0;
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          fcnt_d   = FLUSH_LOAD;
          state_d  = FLUSH_NEXT;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (mem_haz) begin
          stall_c = 1'b1;
        end else begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (fcnt_q <= 3'd1) begin
            fcnt_d  = 3'd0;
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = 3'd0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr)                              stall_cnt_d = '0;
    else if (stall && stall_cnt_q != CNT_MAX)  stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      fcnt_q      <= 3'd0;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Gated by rst_n so the outputs are quiet for the whole reset window.
  assign stall       = rst_n & stall_c;
  assign flush_if_id = rst_n & flush_c;
  assign bubble_ex   = rst_n & bubble_c;
  assign state       = state_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each scenario task drives inputs cycle by
// cycle and compares {stall, flush_if_id, bubble_ex, state} and stall_cnt.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_valid, ex_is_load, ex_redirect;
  logic        mem_req, mem_ready, perf_clr;
  logic        stall, flush_if_id, bubble_ex;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [4:0]  obs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign obs = {stall, flush_if_id, bubble_ex, state};

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .perf_clr(perf_clr), .stall(stall), .flush_if_id(flush_if_id),
    .bubble_ex(bubble_ex), .state(state), .stall_cnt(stall_cnt)
  );

  task automatic idle();
    id_rs1 = 5'd0; id_rs1_used = 1'b0; id_rs2 = 5'd0; id_rs2_used = 1'b0;
    ex_valid = 1'b0; ex_rd = 5'd0; ex_is_load = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rs1, input logic rs1u,
                          input logic [4:0] rs2, input logic rs2u,
                          input logic [4:0] rd, input logic ld);
    id_rs1 = rs1; id_rs1_used = rs1u; id_rs2 = rs2; id_rs2_used = rs2u;
    ex_valid = 1'b1; ex_rd = rd; ex_is_load = ld;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    mem_req = 1'b1;
    #12;
    total++;
    if (obs !== 5'b0 || stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_hold obs=%b cnt=%0d expected obs=00000 cnt=0", obs, stall_cnt);
    end
    idle();
    @(negedge clk); rst_n = 1'b1;
    step();
    total++;
    if (obs !== 5'b0 || stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_release obs=%b cnt=%0d expected obs=00000 cnt=0", obs, stall_cnt);
    end
  endtask

  task automatic test_load_use();
    logic [4:0] exp_v [6] = '{5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000};
    for (int c = 0; c < 6; c++) begin
      idle();
      case (c)
        0: load_use(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1);  // rs2 match
        1: load_use(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);  // rd = x0
        2: load_use(5'd7, 1'b1, 5'd3, 1'b0, 5'd7, 1'b1);  // rs1 match
        3: load_use(5'd7, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1);  // sources unused
        4: load_use(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0);  // not a load
        default: ;
      endcase
      #1;
      total++;
      if (obs !== exp_v[c]) begin
        bad++;
        $display("FAIL load_use c=%0d obs=%b expected=%b", c, obs, exp_v[c]);
      end
      step();
    end
  endtask

  task automatic test_mem_wait();
    logic [4:0] exp_v [5] = '{5'b10000, 5'b10001, 5'b10001, 5'b00001, 5'b00000};
    idle(); perf_clr = 1'b1; step();
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c < 4) begin mem_req = 1'b1; mem_ready = (c == 3); end
      #1;
      total++;
      if (obs !== exp_v[c]) begin
        bad++;
        $display("FAIL mem_wait c=%0d obs=%b expected=%b", c, obs, exp_v[c]);
      end
      step();
    end
    total++;
    if (stall_cnt !== 16'd3) begin
      bad++;
      $display("FAIL mem_wait_cnt got=%0d expected=3", stall_cnt);
    end
  endtask

  task automatic test_redirect();
    logic [4:0] exp_v [4] = '{5'b01100, 5'b01110, 5'b00000, 5'b00000};
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c < 2) begin ex_valid = 1'b1; ex_redirect = 1'b1; end
      if (c == 1) load_use(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
      #1;
      total++;
      if (obs !== exp_v[c]) begin
        bad++;
        $display("FAIL redirect c=%0d obs=%b expected=%b", c, obs, exp_v[c]);
      end
      step();
    end
  endtask

  task automatic test_redirect_mem();
    logic [4:0] exp_v [6] = '{5'b10000, 5'b10001, 5'b01101, 5'b01110, 5'b00000, 5'b00000};
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c < 2) begin ex_valid = 1'b1; ex_redirect = 1'b1; mem_req = 1'b1; end
      if (c == 2) begin mem_req = 1'b1; mem_ready = 1'b1; end
      #1;
      total++;
      if (obs !== exp_v[c]) begin
        bad++;
        $display("FAIL redirect_mem c=%0d obs=%b expected=%b", c, obs, exp_v[c]);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    idle(); perf_clr = 1'b1; step();
    idle(); mem_req = 1'b1;
    repeat (10) step();
    total++;
    if (stall_cnt !== 16'd10 || obs !== 5'b10001) begin
      bad++;
      $display("FAIL pre_reset cnt=%0d obs=%b expected cnt=10 obs=10001", stall_cnt, obs);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 5'b0 || stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL async_reset obs=%b cnt=%0d expected obs=00000 cnt=0", obs, stall_cnt);
    end
    @(posedge clk);
    idle();
    @(negedge clk); rst_n = 1'b1;
    step();
    load_use(5'd0, 1'b0, 5'd12, 1'b1, 5'd12, 1'b1);
    #1;
    total++;
    if (obs !== 5'b00100) begin
      bad++;
      $display("FAIL post_reset_lu obs=%b expected=00100", obs);
    end
    step();
    idle(); mem_req = 1'b1; #1;
    total++;
    if (obs !== 5'b10000) begin
      bad++;
      $display("FAIL post_reset_mem obs=%b expected=10000", obs);
    end
    step();
    mem_ready = 1'b1; #1;
    total++;
    if (obs !== 5'b00001) begin
      bad++;
      $display("FAIL post_reset_ready obs=%b expected=00001", obs);
    end
    step();
    idle(); #1;
    total++;
    if (obs !== 5'b0 || stall_cnt !== 16'd1) begin
      bad++;
      $display("FAIL post_reset_end obs=%b cnt=%0d expected obs=00000 cnt=1", obs, stall_cnt);
    end
  endtask

  task automatic test_counter_sat();
    idle(); mem_req = 1'b1;
    repeat (65541) step();
    total++;
    if (stall_cnt !== 16'hFFFF || stall !== 1'b1) begin
      bad++;
      $display("FAIL cnt_sat cnt=%h stall=%b expected cnt=ffff stall=1", stall_cnt, stall);
    end
    perf_clr = 1'b1; step();
    total++;
    if (stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL cnt_clr got=%h expected=0000", stall_cnt);
    end
    perf_clr = 1'b0; step();
    total++;
    if (stall_cnt !== 16'd1) begin
      bad++;
      $display("FAIL cnt_after_clr got=%h expected=0001", stall_cnt);
    end
    mem_ready = 1'b1; step();
    idle(); #1;
    total++;
    if (obs !== 5'b0 || stall_cnt !== 16'd1) begin
      bad++;
      $display("FAIL cnt_exit obs=%b cnt=%h expected obs=00000 cnt=0001", obs, stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_redirect();
    test_redirect_mem();
    test_async_reset();
    test_counter_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
